// File: rtl/char_hp_ctrl.sv
// rtl/char_hp_ctrl.sv - player HP sequencer: hit arbitration, i-frames, death and respawn
// All outputs are registered and reflect the state/counter being entered on each edge.
module char_hp_ctrl #(
    parameter int MAX_HP         = 10,
    parameter int INVULN_FRAMES  = 60,
    parameter int RESPAWN_FRAMES = 120,
    parameter int BLINK_BIT      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic [1:0] hit_req,
    input  logic [3:0] hit_dmg0,
    input  logic [3:0] hit_dmg1,
    input  logic       heal_req,
    input  logic [3:0] heal_amt,
    output logic [1:0] hit_ack,
    output logic [3:0] char_hp,
    output logic       char_visible,
    output logic       invuln,
    output logic       char_dead,
    output logic       respawn_pulse
);

    localparam int CNT_MAX = (INVULN_FRAMES > RESPAWN_FRAMES) ? INVULN_FRAMES : RESPAWN_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0]    HP_FULL   = 4'(MAX_HP);
    localparam logic [4:0]    HP_FULL5  = 5'(MAX_HP);
    localparam logic [CW-1:0] INV_LAST  = CW'(INVULN_FRAMES);
    localparam logic [CW-1:0] RESP_LAST = CW'(RESPAWN_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIVE,
        S_INVULN,
        S_DEAD,
        S_RESPAWN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hp_q, hp_d;
    logic [1:0]    ack_q, ack_d;
    logic          vis_q, vis_d;
    logic          inv_q, inv_d;
    logic          dead_q, dead_d;
    logic          resp_q, resp_d;

    logic [3:0]    sel_dmg;
    logic [3:0]    dmg_res;
    logic [4:0]    heal_sum;
    logic [3:0]    heal_res;
    logic [CW-1:0] cnt_inc;

    assign sel_dmg  = hit_req[0] ? hit_dmg0 : hit_dmg1;
    assign dmg_res  = (sel_dmg >= hp_q) ? 4'd0 : (hp_q - sel_dmg);
    assign heal_sum = {1'b0, hp_q} + {1'b0, heal_amt};
    assign heal_res = (heal_sum > HP_FULL5) ? HP_FULL : heal_sum[3:0];
    assign cnt_inc  = cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hp_q    <= HP_FULL;
            ack_q   <= 2'b00;
            vis_q   <= 1'b1;
            inv_q   <= 1'b0;
            dead_q  <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            ack_q   <= ack_d;
            vis_q   <= vis_d;
            inv_q   <= inv_d;
            dead_q  <= dead_d;
            resp_q  <= resp_d;
        end
    end

    // Every state entry clears the counter, so a tick coinciding with an entry is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        ack_d   = 2'b00;
        if (game_start) begin
            state_d = S_ALIVE;
            cnt_d   = '0;
            hp_d    = HP_FULL;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ALIVE: begin
                    if (|hit_req) begin
                        ack_d   = hit_req[0] ? 2'b01 : 2'b10;
                        hp_d    = dmg_res;
                        cnt_d   = '0;
                        state_d = (dmg_res == 4'd0) ? S_DEAD : S_INVULN;
                    end else if (heal_req) begin
                        hp_d = heal_res;
                    end
                end
                S_INVULN: begin
                    if (heal_req) hp_d = heal_res;
                    if (frame_tick) begin
                        if (cnt_inc == INV_LAST) begin
                            state_d = S_ALIVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                S_DEAD: begin
                    hp_d = 4'd0;
                    if (frame_tick) begin
                        if (cnt_inc == RESP_LAST) begin
                            state_d = S_RESPAWN;
                            cnt_d   = '0;
                            hp_d    = HP_FULL;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                S_RESPAWN: begin
                    state_d = S_INVULN;
                    cnt_d   = '0;
                    hp_d    = HP_FULL;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        inv_d  = (state_d == S_INVULN);
        dead_d = (state_d == S_DEAD);
        resp_d = (state_d == S_RESPAWN);
        vis_d  = inv_d ? ~cnt_d[BLINK_BIT] : 1'b1;
    end

    assign hit_ack       = ack_q;
    assign char_hp       = hp_q;
    assign char_visible  = vis_q;
    assign invuln        = inv_q;
    assign char_dead     = dead_q;
    assign respawn_pulse = resp_q;

endmodule

// File: tb/tb_char_hp_ctrl.sv
// tb/tb_char_hp_ctrl.sv - scoreboard bench for char_hp_ctrl
module tb_char_hp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       game_start = 1'b0;
    logic [1:0] hit_req = 2'b00;
    logic [3:0] hit_dmg0 = 4'd0;
    logic [3:0] hit_dmg1 = 4'd0;
    logic       heal_req = 1'b0;
    logic [3:0] heal_amt = 4'd0;
    logic [1:0] hit_ack;
    logic [3:0] char_hp;
    logic       char_visible;
    logic       invuln;
    logic       char_dead;
    logic       respawn_pulse;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] ack;
        logic       resp;
        logic [3:0] hp;
        logic       inv;
        logic       dead;
    } exp_t;

    exp_t exp_q[$];

    char_hp_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_start(game_start),
        .hit_req(hit_req), .hit_dmg0(hit_dmg0), .hit_dmg1(hit_dmg1),
        .heal_req(heal_req), .heal_amt(heal_amt), .hit_ack(hit_ack),
        .char_hp(char_hp), .char_visible(char_visible), .invuln(invuln),
        .char_dead(char_dead), .respawn_pulse(respawn_pulse)
    );

    always #5 clk = ~clk;

    // Monitor: every ack or respawn pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (hit_ack != 2'b00 || respawn_pulse) begin
            exp_t got;
            exp_t want;
            got = '{ack: hit_ack, resp: respawn_pulse, hp: char_hp, inv: invuln, dead: char_dead};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event_unexpected ack=%b resp=%b hp=%0d at %0t", hit_ack, respawn_pulse, char_hp, $time);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++;
                    $display("FAIL event ack=%b/%b resp=%b/%b hp=%0d/%0d inv=%b/%b dead=%b/%b (got/want)",
                             got.ack, want.ack, got.resp, want.resp, got.hp, want.hp,
                             got.inv, want.inv, got.dead, want.dead);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        cyc(n);
        frame_tick = 1'b0;
    endtask

    task automatic expect_ev(input logic [1:0] a, input logic r, input logic [3:0] h, input logic i, input logic d);
        exp_q.push_back('{ack: a, resp: r, hp: h, inv: i, dead: d});
    endtask

    initial begin
        #12;
        chk("rst_hp", char_hp, 10);
        chk("rst_vis", char_visible, 1);
        chk("rst_inv", invuln, 0);
        chk("rst_dead", char_dead, 0);
        chk("rst_ack", hit_ack, 0);
        cyc(1);
        rst = 1'b0;

        // IDLE ignores hits
        hit_req = 2'b01; hit_dmg0 = 4'd5;
        cyc(3);
        hit_req = 2'b00;
        chk("idle_hp", char_hp, 10);

        game_start = 1'b1; cyc(1); game_start = 1'b0;
        chk("start_hp", char_hp, 10);
        chk("start_inv", invuln, 0);

        // single contact hit, blink, heal saturation, i-frame expiry
        hit_dmg0 = 4'd3; hit_req = 2'b01;
        expect_ev(2'b01, 1'b0, 4'd7, 1'b1, 1'b0);
        cyc(1); hit_req = 2'b00;
        chk("hit1_vis0", char_visible, 1);
        ticks(4);
        chk("blink_off", char_visible, 0);
        ticks(4);
        chk("blink_on", char_visible, 1);
        heal_req = 1'b1; heal_amt = 4'd15; cyc(1); heal_req = 1'b0;
        chk("heal_sat_hp", char_hp, 10);
        chk("heal_inv", invuln, 1);
        ticks(51);
        chk("inv_59", invuln, 1);
        ticks(1);
        chk("inv_60", invuln, 0);
        chk("alive_vis", char_visible, 1);

        // priority, held projectile accepted on first ALIVE cycle
        hit_dmg0 = 4'd2; hit_dmg1 = 4'd5; hit_req = 2'b11;
        expect_ev(2'b01, 1'b0, 4'd8, 1'b1, 1'b0);
        cyc(1); hit_req = 2'b10;
        ticks(59);
        chk("held_hp", char_hp, 8);
        chk("held_inv", invuln, 1);
        expect_ev(2'b10, 1'b0, 4'd3, 1'b1, 1'b0);
        ticks(1);
        chk("held_alive", invuln, 0);
        cyc(1); hit_req = 2'b00;
        chk("held_hp3", char_hp, 3);

        // lethal hit, death countdown, respawn
        ticks(60);
        hit_dmg0 = 4'd9; hit_req = 2'b01;
        expect_ev(2'b01, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc(1); hit_req = 2'b00;
        chk("dead_vis", char_visible, 1);
        heal_req = 1'b1; heal_amt = 4'd4; cyc(1); heal_req = 1'b0;
        chk("dead_heal_hp", char_hp, 0);
        ticks(119);
        chk("dead_119", char_dead, 1);
        expect_ev(2'b00, 1'b1, 4'd10, 1'b0, 1'b0);
        ticks(1);
        cyc(1);
        chk("spawn_inv", invuln, 1);
        chk("spawn_hp", char_hp, 10);

        // hit beats heal in the same cycle
        ticks(60);
        hit_dmg0 = 4'd4; hit_req = 2'b01;
        expect_ev(2'b01, 1'b0, 4'd6, 1'b1, 1'b0);
        cyc(1); hit_req = 2'b00;
        ticks(60);
        hit_dmg0 = 4'd2; hit_req = 2'b01; heal_req = 1'b1; heal_amt = 4'd4;
        expect_ev(2'b01, 1'b0, 4'd4, 1'b1, 1'b0);
        cyc(1); hit_req = 2'b00; heal_req = 1'b0;
        chk("hit_vs_heal_hp", char_hp, 4);

        // game_start out of DEAD
        ticks(60);
        hit_dmg1 = 4'd15; hit_req = 2'b10;
        expect_ev(2'b10, 1'b0, 4'd0, 1'b0, 1'b1);
        cyc(1); hit_req = 2'b00;
        ticks(10);
        game_start = 1'b1; frame_tick = 1'b1; cyc(1); game_start = 1'b0; frame_tick = 1'b0;
        chk("restart_dead", char_dead, 0);
        chk("restart_hp", char_hp, 10);
        chk("restart_inv", invuln, 0);

        // async reset mid-INVULN
        hit_dmg0 = 4'd1; hit_req = 2'b01;
        expect_ev(2'b01, 1'b0, 4'd9, 1'b1, 1'b0);
        cyc(1); hit_req = 2'b00;
        ticks(30);
        chk("mid_vis", char_visible, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_hp", char_hp, 10);
        chk("arst_inv", invuln, 0);
        chk("arst_vis", char_visible, 1);
        cyc(1);
        rst = 1'b0;
        hit_req = 2'b01;
        cyc(5);
        hit_req = 2'b00;
        chk("post_rst_hp", char_hp, 10);
        chk("post_rst_inv", invuln, 0);

        cyc(2);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
